// File: rtl/lap_stopwatch_pkg.sv
// Shared types and field limits for the lap stopwatch.
// Also provides the preload saturation helper.
package lap_stopwatch_pkg;

    localparam int SEC_W = 6;
    localparam int MIN_W = 6;
    localparam int HR_W  = 5;

    localparam logic [SEC_W-1:0] SEC_MAX = 6'd59;
    localparam logic [MIN_W-1:0] MIN_MAX = 6'd59;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PAUSE,
        EXPIRED
    } sw_state_t;

    function automatic logic [5:0] sat59(
        input logic [5:0] v
    );
        return (v > 6'd59) ? 6'd59 : v;
    endfunction

endpackage

// File: rtl/lap_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy.
// Shared by the stopwatch lap store and the alarm log.
module lap_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic                     head_valid,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt_n;
    logic             push_ok;
    logic             pop_ok;

    assign full      = (count == (AW+1)'(DEPTH));
    assign empty     = ~head_valid;
    assign head_data = mem[rd_ptr];
    assign pop_ok    = pop & head_valid & ~flush;
    // A full FIFO still accepts a push when the head leaves the same cycle.
    assign push_ok   = push & ~flush & (~full | pop_ok);

    always_comb begin
        cnt_n = count;
        case ({push_ok, pop_ok})
            2'b10:   cnt_n = count + 1'b1;
            2'b01:   cnt_n = count - 1'b1;
            default: cnt_n = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            head_valid <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            count      <= cnt_n;
            head_valid <= (cnt_n != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/lap_stopwatch.sv
// Up/down stopwatch with run/pause FSM, expiry and lap FIFO.
// Counts advance only on the shared ms tick enable.
module lap_stopwatch
    import lap_stopwatch_pkg::*;
#(
    parameter int TICKS_PER_SEC = 100,
    parameter int HR_MAX        = 23,
    parameter int LAP_DEPTH     = 8
) (
    input  logic                               i_clk,
    input  logic                               i_rst,
    input  logic                               i_ms_pulse,
    input  logic                               i_start_stop,
    input  logic                               i_lap,
    input  logic                               i_clear,
    input  logic                               i_mode_down,
    input  logic [SEC_W-1:0]                   i_pre_sec,
    input  logic [MIN_W-1:0]                   i_pre_min,
    input  logic [HR_W-1:0]                    i_pre_hr,
    output logic [$clog2(TICKS_PER_SEC)-1:0]   o_tick,
    output logic [SEC_W-1:0]                   o_sec,
    output logic [MIN_W-1:0]                   o_min,
    output logic [HR_W-1:0]                    o_hr,
    output logic                               o_running,
    output logic                               o_expired,
    output logic                               o_wrap,
    output logic                               o_lap_valid,
    output logic [$clog2(TICKS_PER_SEC)+16:0]  o_lap_data,
    input  logic                               i_lap_ready,
    output logic [$clog2(LAP_DEPTH):0]         o_lap_count,
    output logic                               o_lap_ovf
);

    localparam int TW = $clog2(TICKS_PER_SEC);
    localparam int DW = TW + 17;

    localparam logic [TW-1:0]   TICK_MAX = TW'(TICKS_PER_SEC - 1);
    localparam logic [HR_W-1:0] HR_TOP   = HR_W'(HR_MAX);

    sw_state_t       state;
    sw_state_t       state_n;
    logic            mode_dn;
    logic [TW-1:0]   t_n;
    logic [5:0]      s_n;
    logic [5:0]      m_n;
    logic [4:0]      h_n;
    logic            wrap_n;
    logic            cur_zero;
    logic            step_zero;
    logic            do_clear;
    logic            tick_en;
    logic            lap_push;
    logic            lap_pop;
    logic            fifo_full;
    logic            fifo_empty;
    logic [HR_W-1:0] pre_hr_sat;

    assign cur_zero   = ({o_hr, o_min, o_sec, o_tick} == '0);
    assign step_zero  = ({h_n, m_n, s_n, t_n} == '0);
    assign do_clear   = i_clear & (state != RUN);
    // An expired down-count must never step past zero into a borrow.
    assign tick_en    = (state == RUN) & i_ms_pulse
                      & ~(mode_dn & cur_zero);
    assign lap_push   = (state == RUN) & i_lap & ~i_start_stop;
    assign lap_pop    = i_lap_ready & ~fifo_empty;
    assign pre_hr_sat = (i_pre_hr > HR_TOP) ? HR_TOP : i_pre_hr;

    always_comb begin
        t_n    = o_tick;
        s_n    = o_sec;
        m_n    = o_min;
        h_n    = o_hr;
        wrap_n = 1'b0;
        if (mode_dn) begin
            if (o_tick != '0) t_n = o_tick - 1'b1;
            else begin
                t_n = TICK_MAX;
                if (o_sec != '0) s_n = o_sec - 1'b1;
                else begin
                    s_n = SEC_MAX;
                    if (o_min != '0) m_n = o_min - 1'b1;
                    else begin
                        m_n = MIN_MAX;
                        h_n = (o_hr != '0) ? o_hr - 1'b1 : HR_TOP;
                    end
                end
            end
        end else begin
            if (o_tick != TICK_MAX) t_n = o_tick + 1'b1;
            else begin
                t_n = '0;
                if (o_sec != SEC_MAX) s_n = o_sec + 1'b1;
                else begin
                    s_n = '0;
                    if (o_min != MIN_MAX) m_n = o_min + 1'b1;
                    else begin
                        m_n = '0;
                        if (o_hr != HR_TOP) h_n = o_hr + 1'b1;
                        else begin
                            h_n    = '0;
                            wrap_n = 1'b1;
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: begin
                if (!i_clear && i_start_stop) state_n = RUN;
            end
            RUN: begin
                if (i_start_stop) state_n = PAUSE;
                else if (mode_dn && (cur_zero ||
                         (i_ms_pulse && step_zero)))
                    state_n = EXPIRED;
            end
            PAUSE: begin
                if (i_clear)           state_n = IDLE;
                else if (i_start_stop) state_n = RUN;
            end
            EXPIRED: begin
                if (i_clear || i_start_stop) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= IDLE;
            mode_dn   <= 1'b0;
            o_tick    <= '0;
            o_sec     <= '0;
            o_min     <= '0;
            o_hr      <= '0;
            o_running <= 1'b0;
            o_expired <= 1'b0;
            o_wrap    <= 1'b0;
            o_lap_ovf <= 1'b0;
        end else begin
            state     <= state_n;
            o_running <= (state_n == RUN);
            o_expired <= (state_n == EXPIRED);
            o_wrap    <= 1'b0;
            if (state == IDLE && i_start_stop && !i_clear)
                mode_dn <= i_mode_down;
            if (do_clear) begin
                o_tick <= '0;
                o_sec  <= i_mode_down ? sat59(i_pre_sec) : '0;
                o_min  <= i_mode_down ? sat59(i_pre_min) : '0;
                o_hr   <= i_mode_down ? pre_hr_sat : '0;
            end else if (tick_en) begin
                o_tick <= t_n;
                o_sec  <= s_n;
                o_min  <= m_n;
                o_hr   <= h_n;
                o_wrap <= wrap_n & ~mode_dn;
            end
            if (do_clear)
                o_lap_ovf <= 1'b0;
            else if (lap_push && fifo_full && !lap_pop)
                o_lap_ovf <= 1'b1;
        end
    end

    lap_fifo #(
        .WIDTH (DW),
        .DEPTH (LAP_DEPTH)
    ) u_lap_fifo (
        .clk        (i_clk),
        .rst        (i_rst),
        .flush      (do_clear),
        .push       (lap_push),
        .push_data  ({o_hr, o_min, o_sec, o_tick}),
        .pop        (lap_pop),
        .head_data  (o_lap_data),
        .head_valid (o_lap_valid),
        .count      (o_lap_count),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

endmodule
